// File: rtl/adc_spi_pkg.sv
// Shared constants for the ADS131A0x SPI responder: frame geometry, command
// words, FSM encoding and the NULL-command status selection.
package adc_spi_pkg;

  localparam int unsigned WORD_BITS       = 16;
  localparam int unsigned WORDS_PER_FRAME = 2;
  localparam int unsigned FRAME_BITS      = WORD_BITS * WORDS_PER_FRAME;
  // Wide enough to hold the value FRAME_BITS itself.
  localparam int unsigned BIT_CNT_W       = $clog2(FRAME_BITS + 1);

  localparam logic [WORD_BITS-1:0] CMD_NULL   = 16'h0000;
  localparam logic [WORD_BITS-1:0] CMD_UNLOCK = 16'h0655;
  localparam logic [WORD_BITS-1:0] CMD_LOCK   = 16'h0555;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;

  // Status word returned for a NULL command.
  function automatic logic [WORD_BITS-1:0] null_response(
    input logic                 ready,
    input logic                 unlocked,
    input logic [WORD_BITS-1:0] ready_word,
    input logic [WORD_BITS-1:0] unlocked_word
  );
    if (!ready) begin
      return '0;
    end
    return unlocked ? unlocked_word : ready_word;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings the master's SCLK, CS_n and MOSI into the local clock domain and
// produces single-cycle edge strobes on the synchronized copies.
module spi_input_sync (
  input  logic synthesized_clock_4_167Mhz,
  input  logic reset_n,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi
);

  // [0] metastability stage, [1] synchronized value, [2] previous value.
  logic [2:0] r_sclk;
  logic [2:0] r_cs;
  logic [1:0] r_mosi;

  // Synchronizer chains. CS resets to 0 so that leaving reset while the
  // master holds CS low cannot manufacture a CS fall; the spurious rise seen
  // when CS is really high lands in IDLE, where it is ignored.
  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk <= '0;
      r_cs   <= '0;
      r_mosi <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], i_sclk};
      r_cs   <= {r_cs[1:0], i_cs_n};
      r_mosi <= {r_mosi[0], i_mosi};
    end
  end

  assign o_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign o_sclk_fall = ~r_sclk[1] & r_sclk[2];
  assign o_cs_fall   = ~r_cs[1] & r_cs[2];
  assign o_cs_rise   = r_cs[1] & ~r_cs[2];
  // Same depth as the SCLK chain, so it lines up with the fall strobe.
  assign o_mosi      = r_mosi[1];

endmodule

// File: rtl/adc_spi_responder.sv
// ADS131A0x SPI slave emulation: CPHA=1 frames of two 16-bit words, command
// decode with one-frame response latency, and an incrementing data word.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned          READY_DELAY   = 64,
  parameter logic [WORD_BITS-1:0] READY_WORD    = 16'hFF04,
  parameter logic [WORD_BITS-1:0] UNLOCKED_WORD = 16'h2200
) (
  input  logic                 synthesized_clock_4_167Mhz,
  input  logic                 reset_n,
  input  logic                 i_spi_sclk,
  input  logic                 i_spi_cs_n,
  input  logic                 i_spi_mosi,
  input  logic                 i_spi_reset_n,
  output logic                 o_spi_miso,
  output logic                 o_unlocked,
  output logic                 o_ready,
  output logic                 o_frame_done,
  output logic                 o_frame_error,
  output logic                 o_cmd_error,
  output logic [WORD_BITS-1:0] o_last_command,
  output logic [WORD_BITS-1:0] o_frame_count,
  output logic [1:0]           o_state
);

  localparam int unsigned          RDY_W    = $clog2(READY_DELAY + 1);
  localparam logic [RDY_W-1:0]     RDY_MAX  = RDY_W'(READY_DELAY);
  localparam logic [BIT_CNT_W-1:0] BITS_MAX = BIT_CNT_W'(FRAME_BITS);

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;

  spi_input_sync u_sync (
    .synthesized_clock_4_167Mhz (synthesized_clock_4_167Mhz),
    .reset_n                    (reset_n),
    .i_sclk                     (i_spi_sclk),
    .i_cs_n                     (i_spi_cs_n),
    .i_mosi                     (i_spi_mosi),
    .o_sclk_rise                (w_sclk_rise),
    .o_sclk_fall                (w_sclk_fall),
    .o_cs_fall                  (w_cs_fall),
    .o_cs_rise                  (w_cs_rise),
    .o_mosi                     (w_mosi)
  );

  logic [1:0]            r_state,       w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt,     w_bit_cnt_nxt;
  logic [BIT_CNT_W-1:0]  r_rx_cnt,      w_rx_cnt_nxt;
  logic [FRAME_BITS-1:0] r_tx,          w_tx_nxt;
  logic [FRAME_BITS-1:0] r_rx,          w_rx_nxt;
  logic                  r_miso,        w_miso_nxt;
  logic                  r_abort,       w_abort_nxt;
  logic [WORD_BITS-1:0]  r_response,    w_response_nxt;
  logic [WORD_BITS-1:0]  r_data_word,   w_data_word_nxt;
  logic                  r_unlocked,    w_unlocked_nxt;
  logic [RDY_W-1:0]      r_rdy_cnt,     w_rdy_cnt_nxt;
  logic                  r_frame_done,  w_frame_done_nxt;
  logic                  r_frame_error, w_frame_error_nxt;
  logic                  r_cmd_error,   w_cmd_error_nxt;
  logic [WORD_BITS-1:0]  r_last_cmd,    w_last_cmd_nxt;
  logic [WORD_BITS-1:0]  r_frame_count, w_frame_count_nxt;

  logic                 w_ready;
  logic [WORD_BITS-1:0] w_cmd;

  assign w_ready = (r_rdy_cnt == RDY_MAX);
  assign w_cmd   = r_rx[FRAME_BITS-1 -: WORD_BITS];

  // Next-state logic for the frame FSM, command decode and ready counter.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_rx_cnt_nxt      = r_rx_cnt;
    w_tx_nxt          = r_tx;
    w_rx_nxt          = r_rx;
    w_miso_nxt        = r_miso;
    w_abort_nxt       = r_abort;
    w_response_nxt    = r_response;
    w_data_word_nxt   = r_data_word;
    w_unlocked_nxt    = r_unlocked;
    w_last_cmd_nxt    = r_last_cmd;
    w_frame_count_nxt = r_frame_count;
    w_frame_done_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;
    w_cmd_error_nxt   = 1'b0;

    if (!i_spi_reset_n) begin
      w_rdy_cnt_nxt = '0;
    end else if (!w_ready) begin
      w_rdy_cnt_nxt = r_rdy_cnt + 1'b1;
    end else begin
      w_rdy_cnt_nxt = r_rdy_cnt;
    end

    case (r_state)
      ST_IDLE: begin
        // SCLK edges here are ignored, including one coinciding with CS fall.
        w_miso_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_tx_nxt      = {r_response, r_data_word};
          w_miso_nxt    = r_response[WORD_BITS-1];
          w_bit_cnt_nxt = '0;
          w_rx_cnt_nxt  = '0;
          w_abort_nxt   = ~i_spi_reset_n;
        end
      end
      ST_SHIFT: begin
        if (!i_spi_reset_n) begin
          w_abort_nxt = 1'b1;
        end
        if (w_cs_rise) begin
          w_state_nxt = ST_CLOSE;
        end else if (w_sclk_rise && (r_bit_cnt != BITS_MAX)) begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          // The MSB is already on MISO from CS fall; the first rise keeps it
          // so the master's first falling-edge sample sees bit 31.
          if (r_bit_cnt != '0) begin
            w_tx_nxt   = {r_tx[FRAME_BITS-2:0], 1'b0};
            w_miso_nxt = r_tx[FRAME_BITS-2];
          end
        end else if (w_sclk_fall && (r_rx_cnt != BITS_MAX)) begin
          w_rx_nxt     = {r_rx[FRAME_BITS-2:0], w_mosi};
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      ST_CLOSE: begin
        w_state_nxt = ST_IDLE;
        w_miso_nxt  = 1'b0;
        // Frames touched by spi_reset_n are dropped silently.
        if (!r_abort && i_spi_reset_n) begin
          if (r_bit_cnt == BITS_MAX) begin
            w_frame_done_nxt  = 1'b1;
            w_frame_count_nxt = r_frame_count + 1'b1;
            w_data_word_nxt   = r_data_word + 1'b1;
            w_last_cmd_nxt    = w_cmd;
            case (w_cmd)
              CMD_NULL: begin
                w_response_nxt = null_response(w_ready, r_unlocked, READY_WORD, UNLOCKED_WORD);
              end
              CMD_UNLOCK: begin
                w_response_nxt = CMD_UNLOCK;
                w_unlocked_nxt = 1'b1;
              end
              CMD_LOCK: begin
                w_response_nxt = CMD_LOCK;
                w_unlocked_nxt = 1'b0;
              end
              default: begin
                w_response_nxt  = '0;
                w_cmd_error_nxt = 1'b1;
              end
            endcase
          end else begin
            w_frame_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_miso_nxt  = 1'b0;
      end
    endcase

    if (!i_spi_reset_n) begin
      w_response_nxt = '0;
      w_unlocked_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_rx_cnt      <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_miso        <= 1'b0;
      r_abort       <= 1'b0;
      r_response    <= '0;
      r_data_word   <= '0;
      r_unlocked    <= 1'b0;
      r_rdy_cnt     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      r_cmd_error   <= 1'b0;
      r_last_cmd    <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_tx          <= w_tx_nxt;
      r_rx          <= w_rx_nxt;
      r_miso        <= w_miso_nxt;
      r_abort       <= w_abort_nxt;
      r_response    <= w_response_nxt;
      r_data_word   <= w_data_word_nxt;
      r_unlocked    <= w_unlocked_nxt;
      r_rdy_cnt     <= w_rdy_cnt_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_frame_error <= w_frame_error_nxt;
      r_cmd_error   <= w_cmd_error_nxt;
      r_last_cmd    <= w_last_cmd_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  assign o_spi_miso     = r_miso;
  assign o_unlocked     = r_unlocked;
  assign o_ready        = w_ready;
  assign o_frame_done   = r_frame_done;
  assign o_frame_error  = r_frame_error;
  assign o_cmd_error    = r_cmd_error;
  assign o_last_command = r_last_cmd;
  assign o_frame_count  = r_frame_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives CPHA=1 master frames and compares
// against a frame-level model of the ADC command protocol.
module tb_adc_spi_responder;

  localparam int unsigned HALF = 6;   // SCLK half period in clocks
  localparam int unsigned DLY  = 64;

  logic clk = 1'b0;
  logic reset_n, sclk, cs_n, mosi, spi_rst_n;
  logic miso, unlocked, ready, frame_done, frame_error, cmd_error;
  logic [15:0] last_command, frame_count;
  logic [1:0] state;

  always #5 clk = ~clk;

  adc_spi_responder dut (
    .synthesized_clock_4_167Mhz (clk),
    .reset_n                    (reset_n),
    .i_spi_sclk                 (sclk),
    .i_spi_cs_n                 (cs_n),
    .i_spi_mosi                 (mosi),
    .i_spi_reset_n              (spi_rst_n),
    .o_spi_miso                 (miso),
    .o_unlocked                 (unlocked),
    .o_ready                    (ready),
    .o_frame_done               (frame_done),
    .o_frame_error              (frame_error),
    .o_cmd_error                (cmd_error),
    .o_last_command             (last_command),
    .o_frame_count              (frame_count),
    .o_state                    (state)
  );

  int unsigned cyc = 0;
  int n_done = 0, n_ferr = 0, n_cerr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_done)  n_done <= n_done + 1;
    if (frame_error) n_ferr <= n_ferr + 1;
    if (cmd_error)   n_cerr <= n_cerr + 1;
  end

  int vectors = 0, errors = 0;

  // Frame-level model of the device.
  logic [15:0] m_resp, m_data, m_last, m_cnt;
  bit m_unl;
  int unsigned rdy_base;

  logic [31:0] got_word, exp_word;
  int got_done, got_ferr, got_cerr, exp_done, exp_ferr, exp_cerr;
  logic snap_ready, snap_unl, snap_miso, snap_pulse;
  logic [15:0] snap_cnt, snap_last;
  logic [1:0] snap_state;

  function automatic bit model_ready();
    return spi_rst_n && ((cyc - rdy_base) >= DLY);
  endfunction

  task automatic model_reset();
    m_resp = '0; m_data = '0; m_last = '0; m_cnt = '0; m_unl = 0;
  endtask

  // One master transaction. hook 1 pulses reset_n before bit hook_bit,
  // hook 2 drops spi_reset_n for a few clocks before bit hook_bit.
  task automatic do_frame(input logic [15:0] cmd, input int nbits, input int hook,
                          input int hook_bit);
    logic [31:0] tx;
    int d0, e0, c0;
    bit aborted;
    tx = {cmd, 16'($urandom)};
    exp_word = {m_resp, m_data};
    aborted = !spi_rst_n;
    got_word = '0;
    d0 = n_done; e0 = n_ferr; c0 = n_cerr;
    @(negedge clk); cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (hook == 1 && i == hook_bit) begin
        reset_n = 1'b0;
        @(negedge clk);
        snap_ready = ready; snap_unl = unlocked; snap_miso = miso; snap_state = state;
        snap_cnt = frame_count; snap_last = last_command;
        snap_pulse = frame_done | frame_error | cmd_error;
        reset_n = 1'b1; rdy_base = cyc;
        model_reset();
        aborted = 1;
      end
      if (hook == 2 && i == hook_bit) begin
        spi_rst_n = 1'b0; m_resp = '0; m_unl = 0;
        repeat (5) @(negedge clk);
        spi_rst_n = 1'b1; rdy_base = cyc;
        aborted = 1;
      end
      sclk = 1'b1; mosi = tx[31-i];
      repeat (HALF) @(negedge clk);
      got_word = {got_word[30:0], miso};
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    got_done = n_done - d0; got_ferr = n_ferr - e0; got_cerr = n_cerr - c0;
    exp_done = 0; exp_ferr = 0; exp_cerr = 0;
    if (!aborted) begin
      if (nbits != 32) begin
        exp_ferr = 1;
      end else begin
        exp_done = 1;
        case (cmd)
          16'h0000: m_resp = !model_ready() ? 16'h0000 : (m_unl ? 16'h2200 : 16'hFF04);
          16'h0655: begin m_resp = 16'h0655; m_unl = 1; end
          16'h0555: begin m_resp = 16'h0555; m_unl = 0; end
          default:  begin m_resp = 16'h0000; exp_cerr = 1; end
        endcase
        m_last = cmd; m_cnt = m_cnt + 1; m_data = m_data + 1;
      end
    end
  endtask

  task automatic test_reset();
    vectors++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got=%b exp=0", miso); end
    vectors++; if (unlocked !== 1'b0) begin errors++; $display("FAIL rst_unlocked got=%b exp=0", unlocked); end
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
    vectors++; if ({frame_done, frame_error, cmd_error} !== 3'b000) begin
      errors++; $display("FAIL rst_pulses got=%b exp=000", {frame_done, frame_error, cmd_error}); end
    vectors++; if (last_command !== 16'h0) begin errors++; $display("FAIL rst_last got=%h exp=0000", last_command); end
    vectors++; if (frame_count !== 16'h0) begin errors++; $display("FAIL rst_count got=%h exp=0000", frame_count); end
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
  endtask

  task automatic test_ready();
    int k;
    @(negedge clk); spi_rst_n = 1'b0; m_resp = '0; m_unl = 0;
    repeat (20) @(negedge clk);
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL rdy_low got=%b exp=0", ready); end
    do_frame(16'h0000, 32, 0, 0);
    vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL rdy_ignored_word got=%h exp=%h", got_word, exp_word); end
    vectors++; if (got_done != 0 || got_ferr != 0) begin
      errors++; $display("FAIL rdy_ignored_pulses got=%0d/%0d exp=0/0", got_done, got_ferr); end
    spi_rst_n = 1'b1; rdy_base = cyc; k = 0;
    while (!ready && k < 200) begin @(negedge clk); k++; end
    vectors++; if (k != DLY) begin errors++; $display("FAIL rdy_delay got=%0d exp=%0d", k, DLY); end
    for (int f = 0; f < 3; f++) begin
      do_frame(16'h0000, 32, 0, 0);
      vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL rdy_null%0d got=%h exp=%h", f, got_word, exp_word); end
    end
  endtask

  task automatic test_unlock_lock();
    logic [15:0] cmds [7];
    cmds = '{16'h0000, 16'h0655, 16'h0000, 16'h0000, 16'h0555, 16'h0000, 16'h0000};
    for (int f = 0; f < 7; f++) begin
      do_frame(cmds[f], 32, 0, 0);
      vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL ul_word%0d got=%h exp=%h", f, got_word, exp_word); end
      vectors++; if (unlocked !== m_unl) begin errors++; $display("FAIL ul_unlocked%0d got=%b exp=%b", f, unlocked, m_unl); end
      vectors++; if (got_done != exp_done) begin errors++; $display("FAIL ul_done%0d got=%0d exp=%0d", f, got_done, exp_done); end
    end
  endtask

  task automatic test_short_frame();
    do_frame(16'h0655, 17, 0, 0);
    vectors++; if (got_ferr != 1 || got_done != 0) begin
      errors++; $display("FAIL short_pulses got=%0d/%0d exp=1/0", got_ferr, got_done); end
    vectors++; if (frame_count !== m_cnt) begin errors++; $display("FAIL short_count got=%h exp=%h", frame_count, m_cnt); end
    do_frame(16'h0000, 32, 0, 0);
    vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL short_next got=%h exp=%h", got_word, exp_word); end
    vectors++; if (got_done != 1 || got_ferr != 0) begin
      errors++; $display("FAIL short_next_pulses got=%0d/%0d exp=1/0", got_done, got_ferr); end
  endtask

  task automatic test_unknown_cmd();
    do_frame(16'h1234, 32, 0, 0);
    vectors++; if (got_cerr != 1) begin errors++; $display("FAIL unk_cmd_error got=%0d exp=1", got_cerr); end
    vectors++; if (last_command !== 16'h1234) begin errors++; $display("FAIL unk_last got=%h exp=1234", last_command); end
    do_frame(16'h0000, 32, 0, 0);
    vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL unk_next got=%h exp=%h", got_word, exp_word); end
  endtask

  task automatic test_random();
    logic [15:0] c;
    for (int f = 0; f < 16; f++) begin
      case ($urandom_range(0, 3))
        0: c = 16'h0000;
        1: c = 16'h0655;
        2: c = 16'h0555;
        default: c = 16'($urandom);
      endcase
      do_frame(c, 32, 0, 0);
      vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL rnd_word%0d got=%h exp=%h", f, got_word, exp_word); end
      vectors++; if (got_cerr != exp_cerr) begin errors++; $display("FAIL rnd_cerr%0d got=%0d exp=%0d", f, got_cerr, exp_cerr); end
      vectors++; if (last_command !== m_last) begin errors++; $display("FAIL rnd_last%0d got=%h exp=%h", f, last_command, m_last); end
      vectors++; if (frame_count !== m_cnt) begin errors++; $display("FAIL rnd_count%0d got=%h exp=%h", f, frame_count, m_cnt); end
      vectors++; if (unlocked !== m_unl) begin errors++; $display("FAIL rnd_unl%0d got=%b exp=%b", f, unlocked, m_unl); end
    end
  endtask

  task automatic test_spi_reset_mid_frame();
    do_frame(16'h0655, 32, 0, 0);
    do_frame(16'h0000, 32, 2, 12);
    vectors++; if (got_done != 0 || got_ferr != 0) begin
      errors++; $display("FAIL spirst_pulses got=%0d/%0d exp=0/0", got_done, got_ferr); end
    vectors++; if (frame_count !== m_cnt) begin errors++; $display("FAIL spirst_count got=%h exp=%h", frame_count, m_cnt); end
    vectors++; if (unlocked !== 1'b0) begin errors++; $display("FAIL spirst_unl got=%b exp=0", unlocked); end
    do_frame(16'h0000, 32, 0, 0);
    vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL spirst_next got=%h exp=%h", got_word, exp_word); end
  endtask

  task automatic test_reset_mid_frame();
    do_frame(16'h0655, 32, 0, 0);
    do_frame(16'h0000, 32, 1, 10);
    vectors++; if ({snap_ready, snap_unl, snap_miso, snap_pulse} !== 4'b0000) begin
      errors++; $display("FAIL midrst_bits got=%b exp=0000", {snap_ready, snap_unl, snap_miso, snap_pulse}); end
    vectors++; if ({snap_cnt, snap_last} !== 32'h0) begin
      errors++; $display("FAIL midrst_regs got=%h exp=00000000", {snap_cnt, snap_last}); end
    vectors++; if (snap_state !== 2'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", snap_state); end
    vectors++; if (got_done != 0 || got_ferr != 0) begin
      errors++; $display("FAIL midrst_pulses got=%0d/%0d exp=0/0", got_done, got_ferr); end
    do_frame(16'h0000, 32, 0, 0);
    vectors++; if (got_word !== exp_word) begin errors++; $display("FAIL midrst_next got=%h exp=%h", got_word, exp_word); end
    vectors++; if (frame_count !== m_cnt) begin errors++; $display("FAIL midrst_count got=%h exp=%h", frame_count, m_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; spi_rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1; rdy_base = cyc;
    @(negedge clk);
    test_reset();
    test_ready();
    test_unlock_lock();
    test_short_frame();
    test_unknown_cmd();
    test_random();
    test_spi_reset_mid_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
